// File: rtl/softproc_pio_ext.sv
`default_nettype none
// ============================================================================
//  Module   : softproc_pio_ext
//  Brief    : Multi-bit Avalon-MM PIO with synchronised/filtered inputs, edge
//             capture with W1C, maskable level IRQ and set/clear outputs.
//  Revision : 1.0
// ============================================================================
module softproc_pio_ext #(
  parameter int          WIDTH      = 8,
  parameter int          FILTER_LEN = 0,
  parameter logic [31:0] RESET_OUT  = 32'h0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] out_oe,
  output logic             irq
);

  localparam logic [WIDTH-1:0] c_reset_out = RESET_OUT[WIDTH-1:0];

  logic [WIDTH-1:0] s1_q, s2_q, f_q, fprev_q;
  logic [WIDTH-1:0] out_q, out_d, dir_q, mask_q, rise_q, fall_q;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [31:0]      rd_q, rd_d;

  logic             wr_w;
  logic [WIDTH-1:0] wd_w, ev_w, clr_w;

  assign wr_w  = chipselect & ~write_n;
  assign wd_w  = writedata[WIDTH-1:0];
  assign ev_w  = (f_q & ~fprev_q & rise_q) | (~f_q & fprev_q & fall_q);
  assign clr_w = (wr_w && address == 3'd3) ? wd_w : '0;
  // An edge arriving with a W1C on the same bit keeps the bit set.
  assign cap_d = (cap_q & ~clr_w) | ev_w;

  always_comb begin
    out_d = out_q;
    if (wr_w) begin
      case (address)
        3'd0:    out_d = wd_w;
        3'd4:    out_d = out_q | wd_w;
        3'd5:    out_d = out_q & ~wd_w;
        default: out_d = out_q;
      endcase
    end
  end

  always_comb begin
    rd_d = '0;
    if (chipselect) begin
      case (address)
        3'd0:    rd_d[WIDTH-1:0] = f_q;
        3'd1:    rd_d[WIDTH-1:0] = dir_q;
        3'd2:    rd_d[WIDTH-1:0] = mask_q;
        3'd3:    rd_d[WIDTH-1:0] = cap_q;
        3'd6:    rd_d[WIDTH-1:0] = rise_q;
        3'd7:    rd_d[WIDTH-1:0] = fall_q;
        default: rd_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q    <= '0;
      s2_q    <= '0;
      fprev_q <= '0;
      out_q   <= c_reset_out;
      dir_q   <= '0;
      mask_q  <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      cap_q   <= '0;
      rd_q    <= '0;
    end else begin
      s1_q    <= in_port;
      s2_q    <= s1_q;
      fprev_q <= f_q;
      out_q   <= out_d;
      cap_q   <= cap_d;
      rd_q    <= rd_d;
      if (wr_w) begin
        case (address)
          3'd1:    dir_q  <= wd_w;
          3'd2:    mask_q <= wd_w;
          3'd6:    rise_q <= wd_w;
          3'd7:    fall_q <= wd_w;
          default: ;
        endcase
      end
    end
  end

  generate
    if (FILTER_LEN == 0) begin : g_bypass
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) f_q <= '0;
        else          f_q <= s2_q;
      end
    end else begin : g_filter
      localparam logic [7:0] c_filt_len = 8'(FILTER_LEN);
      logic [7:0] cnt_q [WIDTH];
      // A new level is accepted once it has differed from f for
      // FILTER_LEN+1 consecutive samples, giving cap at N+3+FILTER_LEN.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          f_q <= '0;
          for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (s2_q[i] == f_q[i]) begin
              cnt_q[i] <= '0;
            end else if (cnt_q[i] == c_filt_len) begin
              f_q[i]   <= s2_q[i];
              cnt_q[i] <= '0;
            end else begin
              cnt_q[i] <= cnt_q[i] + 8'd1;
            end
          end
        end
      end
    end

    if (WIDTH < 32) begin : g_unused
      logic unused_wdata_w;
      assign unused_wdata_w = ^writedata[31:WIDTH];
    end
  endgenerate

  assign readdata = rd_q;
  assign out_port = out_q;
  assign out_oe   = dir_q;
  assign irq      = |(cap_q & mask_q);

endmodule
`default_nettype wire

// File: tb/tb_softproc_pio_ext.sv
`default_nettype none
// ============================================================================
//  Module   : tb_softproc_pio_ext
//  Brief    : Scoreboard bench for softproc_pio_ext (bypass and filtered).
//  Revision : 1.0
// ============================================================================
module tb_softproc_pio_ext;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        cs0, cs1, write_n;
  logic [31:0] writedata;
  logic [31:0] rdata0, rdata1;
  logic [7:0]  pin0, pin1, in0, out0, oe0, out1, oe1;
  logic        irq0, irq1, loop_en;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  assign in0 = loop_en ? out0 : pin0;

  softproc_pio_ext #(.WIDTH(8), .FILTER_LEN(0), .RESET_OUT(32'hA5)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs0),
    .write_n(write_n), .writedata(writedata), .readdata(rdata0),
    .in_port(in0), .out_port(out0), .out_oe(oe0), .irq(irq0));

  softproc_pio_ext #(.WIDTH(8), .FILTER_LEN(4), .RESET_OUT(32'h0)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs1),
    .write_n(write_n), .writedata(writedata), .readdata(rdata1),
    .in_port(pin1), .out_port(out1), .out_oe(oe1), .irq(irq1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input bit sel, input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; write_n = 1'b0; cs0 = !sel; cs1 = sel;
    @(posedge clk);
    #1;
    write_n = 1'b1; cs0 = 1'b0; cs1 = 1'b0;
  endtask

  task automatic rd(input bit sel, input logic [2:0] a, input logic [31:0] e, input string tag);
    @(negedge clk);
    address = a; write_n = 1'b1; cs0 = !sel; cs1 = sel;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    cs0 = 1'b0; cs1 = 1'b0;
    check(tag, sel ? rdata1 : rdata0, exp_q.pop_front());
  endtask

  initial begin
    reset_n = 1'b0; address = '0; cs0 = 0; cs1 = 0; write_n = 1'b1;
    writedata = '0; pin0 = '0; pin1 = '0; loop_en = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Reset state
    for (int a = 0; a < 8; a++) rd(0, 3'(a), 32'h0, $sformatf("reset_rd%0d", a));
    check("reset_out_port", {24'h0, out0}, 32'hA5);
    check("reset_out_oe", {24'h0, oe0}, 32'h0);
    check("reset_irq", {31'h0, irq0}, 32'h0);

    // Rising-edge capture latency with bypassed filter
    wr(0, 3'd6, 32'h01);
    wr(0, 3'd2, 32'h01);
    @(negedge clk);
    pin0 = 8'h01;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("rise_irq_e%0d", k), {31'h0, irq0}, {31'h0, k == 3});
    end
    rd(0, 3'd3, 32'h01, "rise_cap");
    wr(0, 3'd3, 32'h01);
    pin0 = 8'h00;
    repeat (5) @(posedge clk);
    rd(0, 3'd3, 32'h00, "fall_disabled_cap");
    check("fall_disabled_irq", {31'h0, irq0}, 32'h0);

    // Direction register
    wr(0, 3'd1, 32'h3C);
    rd(0, 3'd1, 32'h3C, "dir_rd");
    check("dir_oe", {24'h0, oe0}, 32'h3C);

    // Output set/clear with loopback
    wr(0, 3'd0, 32'h00);
    wr(0, 3'd4, 32'hF0);
    wr(0, 3'd5, 32'h30);
    check("outsetclr_port", {24'h0, out0}, 32'hC0);
    loop_en = 1'b1;
    repeat (4) @(posedge clk);
    rd(0, 3'd0, 32'hC0, "loop_data");
    rd(0, 3'd4, 32'h00, "outset_rd");
    rd(0, 3'd5, 32'h00, "outclr_rd");
    loop_en = 1'b0;
    repeat (5) @(posedge clk);

    // Clear vs coincident edge
    wr(0, 3'd7, 32'hFF);
    @(negedge clk); pin0 = 8'h05;
    repeat (5) @(posedge clk);
    @(negedge clk); pin0 = 8'h00;
    repeat (5) @(posedge clk);
    rd(0, 3'd3, 32'h05, "cap_pending");
    @(negedge clk); pin0 = 8'h04;
    repeat (5) @(posedge clk);
    @(negedge clk); pin0 = 8'h00;
    repeat (3) @(posedge clk);
    wr(0, 3'd3, 32'h04);
    rd(0, 3'd3, 32'h05, "edge_wins");
    check("irq_before_clr", {31'h0, irq0}, 32'h1);
    wr(0, 3'd3, 32'h05);
    check("irq_after_clr", {31'h0, irq0}, 32'h0);
    rd(0, 3'd3, 32'h00, "cap_cleared");

    // Glitch filter on the FILTER_LEN=4 instance
    wr(1, 3'd6, 32'h01);
    wr(1, 3'd2, 32'h01);
    @(negedge clk); pin1 = 8'h01;
    repeat (3) @(negedge clk);
    pin1 = 8'h00;
    repeat (12) @(posedge clk);
    #1;
    check("short_pulse_irq", {31'h0, irq1}, 32'h0);
    rd(1, 3'd3, 32'h00, "short_pulse_cap");
    @(negedge clk); pin1 = 8'h01;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (k >= 5) check($sformatf("long_pulse_irq_e%0d", k), {31'h0, irq1}, {31'h0, k == 7});
      if (k == 5) pin1 = 8'h00;
    end
    rd(1, 3'd3, 32'h01, "long_pulse_cap");

    // Asynchronous reset mid-operation
    wr(0, 3'd6, 32'hFF);
    wr(0, 3'd2, 32'hFF);
    @(negedge clk); pin0 = 8'hFF;
    repeat (5) @(posedge clk);
    rd(0, 3'd3, 32'hFF, "cap_all");
    @(negedge clk); pin1 = 8'h01;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("irq0_pre_rst", {31'h0, irq0}, 32'h1);
    check("irq1_pre_rst", {31'h0, irq1}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_irq0", {31'h0, irq0}, 32'h0);
    check("rst_irq1", {31'h0, irq1}, 32'h0);
    check("rst_out0", {24'h0, out0}, 32'hA5);
    check("rst_oe0", {24'h0, oe0}, 32'h0);
    check("rst_rdata0", rdata0, 32'h0);
    pin0 = 8'h00; pin1 = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    rd(0, 3'd3, 32'h00, "post_rst_cap0");
    rd(1, 3'd3, 32'h00, "post_rst_cap1");
    rd(0, 3'd6, 32'h00, "post_rst_rise0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
